// File: rtl/rob_banked_pkg.sv
// rtl/rob_banked_pkg.sv - shared sizing, slot and pointer types for the banked reorder buffer
package rob_banked_pkg;

  localparam int NUM_BANKS            = 2;
  localparam int DISPATCH_WIDTH       = NUM_BANKS;
  localparam int ROB_ROWS             = 16;
  localparam int ROB_ADDR_WIDTH       = $clog2(ROB_ROWS);
  localparam int WB_PORTS             = 3;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;

  localparam int ROW_W  = ROB_ADDR_WIDTH;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PREG_W = PHYS_REGS_ADDR_WIDTH;
  localparam int AREG_W = 5;

  typedef logic [ROW_W-1:0] rob_ptr_t;
  typedef logic [ROW_W:0]   rob_cnt_t;

  localparam rob_ptr_t PTR_ONE   = rob_ptr_t'(1);
  localparam rob_cnt_t CNT_ONE   = rob_cnt_t'(1);
  localparam rob_cnt_t CNT_ROWS  = rob_cnt_t'(ROB_ROWS);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [PREG_W-1:0] phys_rd;
    logic [AREG_W-1:0] arch_rd;
  } rob_slot_t;

endpackage

// File: rtl/rob_bank.sv
// rtl/rob_bank.sv - one slot column of the ROB: dispatch write, writeback done-set, head read, retire clear
module rob_bank
  import rob_banked_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      wr_en_i,
  input  logic [ROW_W-1:0]          wr_row_i,
  input  logic                      wr_valid_i,
  input  logic [PREG_W-1:0]         wr_phys_i,
  input  logic [AREG_W-1:0]         wr_arch_i,
  input  logic [WB_PORTS-1:0]       wb_en_i,
  input  logic [WB_PORTS*ROW_W-1:0] wb_row_i,
  input  logic                      clr_en_i,
  input  logic [ROW_W-1:0]          clr_row_i,
  input  logic [ROW_W-1:0]          head_row_i,
  output logic                      head_valid_o,
  output logic                      head_done_o,
  output logic [PREG_W-1:0]         head_phys_o,
  output logic [AREG_W-1:0]         head_arch_o
);

  rob_slot_t slot_q [ROB_ROWS];
  rob_slot_t slot_d [ROB_ROWS];

  always_comb begin
    for (int r = 0; r < ROB_ROWS; r++) slot_d[r] = slot_q[r];
    // Writebacks only land on allocated slots, so stray completions are dropped.
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_en_i[p] && slot_q[wb_row_i[p*ROW_W +: ROW_W]].valid)
        slot_d[wb_row_i[p*ROW_W +: ROW_W]].done = 1'b1;
    end
    if (clr_en_i) begin
      slot_d[clr_row_i].valid = 1'b0;
      slot_d[clr_row_i].done  = 1'b0;
    end
    if (wr_en_i) begin
      slot_d[wr_row_i].valid   = wr_valid_i;
      slot_d[wr_row_i].done    = 1'b0;
      slot_d[wr_row_i].phys_rd = wr_phys_i;
      slot_d[wr_row_i].arch_rd = wr_arch_i;
    end
    if (flush_i) begin
      for (int r = 0; r < ROB_ROWS; r++) begin
        slot_d[r].valid = 1'b0;
        slot_d[r].done  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROB_ROWS; r++) slot_q[r] <= '0;
    end else begin
      for (int r = 0; r < ROB_ROWS; r++) slot_q[r] <= slot_d[r];
    end
  end

  assign head_valid_o = slot_q[head_row_i].valid;
  assign head_done_o  = slot_q[head_row_i].done;
  assign head_phys_o  = slot_q[head_row_i].phys_rd;
  assign head_arch_o  = slot_q[head_row_i].arch_rd;

endmodule

// File: rtl/rob_banked.sv
// rtl/rob_banked.sv - banked reorder buffer: in-order row allocate, multi-port writeback, head-row commit, flush
module rob_banked
  import rob_banked_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_BANKS-1:0]        dispatch_en,
  input  logic [NUM_BANKS*PREG_W-1:0] dispatch_phys_rd,
  input  logic [NUM_BANKS*AREG_W-1:0] dispatch_arch_rd,
  output logic [ROW_W-1:0]            dispatch_rob_addr,
  output logic [NUM_BANKS*BANK_W-1:0] dispatch_bank_addr,
  output logic                        full,
  input  logic [WB_PORTS-1:0]         writeback_en,
  input  logic [WB_PORTS*ROW_W-1:0]   writeback_rob_addr,
  input  logic [WB_PORTS*BANK_W-1:0]  writeback_bank_addr,
  output logic [NUM_BANKS-1:0]        commit_en,
  output logic [NUM_BANKS*PREG_W-1:0] commit_phys_rd,
  output logic [NUM_BANKS*AREG_W-1:0] commit_arch_rd,
  input  logic                        flush,
  output logic                        empty
);

  rob_ptr_t head_q, head_d;
  rob_ptr_t tail_q, tail_d;
  rob_cnt_t count_q, count_d;

  logic                 do_disp;
  logic                 do_commit;
  logic [NUM_BANKS-1:0] slot_ok;
  logic [NUM_BANKS-1:0] head_valid;

  assign full              = (count_q == CNT_ROWS);
  assign empty             = (count_q == '0);
  assign dispatch_rob_addr = tail_q;
  assign do_disp           = (|dispatch_en) && !full && !flush;
  // A row retires only once every occupied slot has completed.
  assign do_commit         = !empty && !flush && (&slot_ok);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WB_PORTS-1:0] wb_hit;
    logic                head_done;

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
      assign wb_hit[p] = writeback_en[p] &&
                         (writeback_bank_addr[p*BANK_W +: BANK_W] == BANK_W'(b));
    end

    rob_bank u_bank (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush),
      .wr_en_i      (do_disp),
      .wr_row_i     (tail_q),
      .wr_valid_i   (dispatch_en[b]),
      .wr_phys_i    (dispatch_phys_rd[b*PREG_W +: PREG_W]),
      .wr_arch_i    (dispatch_arch_rd[b*AREG_W +: AREG_W]),
      .wb_en_i      (wb_hit),
      .wb_row_i     (writeback_rob_addr),
      .clr_en_i     (do_commit),
      .clr_row_i    (head_q),
      .head_row_i   (head_q),
      .head_valid_o (head_valid[b]),
      .head_done_o  (head_done),
      .head_phys_o  (commit_phys_rd[b*PREG_W +: PREG_W]),
      .head_arch_o  (commit_arch_rd[b*AREG_W +: AREG_W])
    );

    assign slot_ok[b]                             = !head_valid[b] || head_done;
    assign commit_en[b]                           = do_commit && head_valid[b];
    assign dispatch_bank_addr[b*BANK_W +: BANK_W] = BANK_W'(b);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_disp)   tail_d = tail_q + PTR_ONE;
      if (do_commit) head_d = head_q + PTR_ONE;
      if (do_disp && !do_commit)      count_d = count_q + CNT_ONE;
      else if (!do_disp && do_commit) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_banked.sv
// tb/tb_rob_banked.sv - directed self-checking bench for rob_banked
module tb_rob_banked;
  import rob_banked_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NUM_BANKS-1:0]        dispatch_en;
  logic [NUM_BANKS*PREG_W-1:0] dispatch_phys_rd;
  logic [NUM_BANKS*AREG_W-1:0] dispatch_arch_rd;
  logic [ROW_W-1:0]            dispatch_rob_addr;
  logic [NUM_BANKS*BANK_W-1:0] dispatch_bank_addr;
  logic                        full;
  logic [WB_PORTS-1:0]         writeback_en;
  logic [WB_PORTS*ROW_W-1:0]   writeback_rob_addr;
  logic [WB_PORTS*BANK_W-1:0]  writeback_bank_addr;
  logic [NUM_BANKS-1:0]        commit_en;
  logic [NUM_BANKS*PREG_W-1:0] commit_phys_rd;
  logic [NUM_BANKS*AREG_W-1:0] commit_arch_rd;
  logic                        flush;
  logic                        empty;

  int checks = 0;
  int passes = 0;

  rob_banked dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dispatch_en         (dispatch_en),
    .dispatch_phys_rd    (dispatch_phys_rd),
    .dispatch_arch_rd    (dispatch_arch_rd),
    .dispatch_rob_addr   (dispatch_rob_addr),
    .dispatch_bank_addr  (dispatch_bank_addr),
    .full                (full),
    .writeback_en        (writeback_en),
    .writeback_rob_addr  (writeback_rob_addr),
    .writeback_bank_addr (writeback_bank_addr),
    .commit_en           (commit_en),
    .commit_phys_rd      (commit_phys_rd),
    .commit_arch_rd      (commit_arch_rd),
    .flush               (flush),
    .empty               (empty)
  );

  always #5 clk = ~clk;

  task automatic clr_inputs();
    dispatch_en         = '0;
    dispatch_phys_rd    = '0;
    dispatch_arch_rd    = '0;
    writeback_en        = '0;
    writeback_rob_addr  = '0;
    writeback_bank_addr = '0;
    flush               = 1'b0;
  endtask

  // Advance one edge and leave time for inputs to be driven before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [1:0] en, input int p0, input int p1, input int a0, input int a1);
    dispatch_en      = en;
    dispatch_phys_rd = {PREG_W'(p1), PREG_W'(p0)};
    dispatch_arch_rd = {AREG_W'(a1), AREG_W'(a0)};
  endtask

  task automatic set_wb(input int p, input int row, input int bank);
    writeback_en[p]                            = 1'b1;
    writeback_rob_addr[p*ROW_W +: ROW_W]       = ROW_W'(row);
    writeback_bank_addr[p*BANK_W +: BANK_W]    = BANK_W'(bank);
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (full !== 1'b0) $display("FAIL reset_full got %0b exp 0", full); else passes++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b exp 1", empty); else passes++;
    checks++; if (commit_en !== 2'b00) $display("FAIL reset_commit got %b exp 00", commit_en); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd0) $display("FAIL reset_addr got %0d exp 0", dispatch_rob_addr); else passes++;
    checks++; if (dispatch_bank_addr !== 2'b10) $display("FAIL bank_addr got %b exp 10", dispatch_bank_addr); else passes++;
  endtask

  task automatic test_dispatch();
    set_disp(2'b11, 5, 6, 1, 2);
    #1;
    checks++; if (dispatch_rob_addr !== 4'd0) $display("FAIL disp_addr got %0d exp 0", dispatch_rob_addr); else passes++;
    tick();
    clr_inputs();
    #1;
    checks++; if (empty !== 1'b0) $display("FAIL disp_empty got %0b exp 0", empty); else passes++;
    checks++; if (commit_en !== 2'b00) $display("FAIL disp_commit got %b exp 00", commit_en); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd1) $display("FAIL disp_tail got %0d exp 1", dispatch_rob_addr); else passes++;
  endtask

  task automatic test_writeback();
    set_wb(0, 0, 1);
    tick();
    clr_inputs();
    set_wb(0, 0, 0);
    #1;
    checks++; if (commit_en !== 2'b00) $display("FAIL wb_partial_commit got %b exp 00", commit_en); else passes++;
    tick();
    clr_inputs();
    #1;
    checks++; if (commit_en !== 2'b11) $display("FAIL wb_commit got %b exp 11", commit_en); else passes++;
    checks++; if (commit_phys_rd !== {6'd6, 6'd5}) $display("FAIL wb_phys got %h exp %h", commit_phys_rd, {6'd6, 6'd5}); else passes++;
    checks++; if (commit_arch_rd !== {5'd2, 5'd1}) $display("FAIL wb_arch got %h exp %h", commit_arch_rd, {5'd2, 5'd1}); else passes++;
    tick();
    checks++; if (empty !== 1'b1) $display("FAIL wb_empty_after got %0b exp 1", empty); else passes++;
    checks++; if (commit_en !== 2'b00) $display("FAIL wb_commit_after got %b exp 00", commit_en); else passes++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < ROB_ROWS; i++) begin
      set_disp(2'b11, 2*i + 10, 2*i + 11, i, i + 16);
      tick();
      if (i == ROB_ROWS - 2) begin
        checks++; if (full !== 1'b0) $display("FAIL full_early got %0b exp 0", full); else passes++;
      end
    end
    checks++; if (full !== 1'b1) $display("FAIL full_set got %0b exp 1", full); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd0) $display("FAIL full_tail got %0d exp 0", dispatch_rob_addr); else passes++;
    set_disp(2'b11, 50, 51, 7, 8);
    tick();
    checks++; if (full !== 1'b1) $display("FAIL full_drop got %0b exp 1", full); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd0) $display("FAIL full_drop_tail got %0d exp 0", dispatch_rob_addr); else passes++;
    checks++; if (empty !== 1'b0) $display("FAIL full_empty got %0b exp 0", empty); else passes++;
  endtask

  task automatic test_full_commit();
    set_disp(2'b11, 40, 41, 3, 4);
    set_wb(0, 0, 0);
    set_wb(1, 0, 1);
    tick();
    writeback_en = '0;
    #1;
    checks++; if (commit_en !== 2'b11) $display("FAIL fc_commit got %b exp 11", commit_en); else passes++;
    checks++; if (commit_phys_rd !== {6'd11, 6'd10}) $display("FAIL fc_phys got %h exp %h", commit_phys_rd, {6'd11, 6'd10}); else passes++;
    checks++; if (full !== 1'b1) $display("FAIL fc_full_hold got %0b exp 1", full); else passes++;
    tick();
    checks++; if (full !== 1'b0) $display("FAIL fc_full_clear got %0b exp 0", full); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd0) $display("FAIL fc_tail_wrap got %0d exp 0", dispatch_rob_addr); else passes++;
    tick();
    clr_inputs();
    #1;
    checks++; if (full !== 1'b1) $display("FAIL fc_refill got %0b exp 1", full); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd1) $display("FAIL fc_tail_after got %0d exp 1", dispatch_rob_addr); else passes++;
  endtask

  task automatic test_partial();
    do_reset();
    set_disp(2'b01, 7, 9, 3, 4);
    tick();
    clr_inputs();
    set_wb(0, 0, 0);
    set_wb(1, 0, 1);
    #1;
    checks++; if (commit_en !== 2'b00) $display("FAIL part_nobypass got %b exp 00", commit_en); else passes++;
    tick();
    clr_inputs();
    #1;
    checks++; if (commit_en !== 2'b01) $display("FAIL part_commit got %b exp 01", commit_en); else passes++;
    checks++; if (commit_phys_rd[5:0] !== 6'd7) $display("FAIL part_phys got %0d exp 7", commit_phys_rd[5:0]); else passes++;
    checks++; if (commit_arch_rd[4:0] !== 5'd3) $display("FAIL part_arch got %0d exp 3", commit_arch_rd[4:0]); else passes++;
    tick();
    checks++; if (empty !== 1'b1) $display("FAIL part_empty got %0b exp 1", empty); else passes++;
    checks++; if (commit_en !== 2'b00) $display("FAIL part_after got %b exp 00", commit_en); else passes++;
  endtask

  // Fills five rows with row 0 complete, then kills the pipeline by flush or by reset.
  task automatic load_five();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_disp(2'b11, i + 20, i + 30, i + 1, i + 10);
      if (i == 4) begin
        set_wb(0, 0, 0);
        set_wb(1, 0, 1);
      end
      tick();
      clr_inputs();
    end
    set_disp(2'b11, 60, 61, 5, 6);
    set_wb(0, 1, 0);
    set_wb(1, 1, 1);
    set_wb(2, 2, 0);
  endtask

  task automatic test_flush();
    load_five();
    flush = 1'b1;
    #1;
    checks++; if (commit_en !== 2'b00) $display("FAIL flush_commit got %b exp 00", commit_en); else passes++;
    tick();
    clr_inputs();
    #1;
    checks++; if (empty !== 1'b1) $display("FAIL flush_empty got %0b exp 1", empty); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd0) $display("FAIL flush_tail got %0d exp 0", dispatch_rob_addr); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL flush_full got %0b exp 0", full); else passes++;
    set_disp(2'b11, 2, 3, 4, 5);
    tick();
    clr_inputs();
    #1;
    checks++; if (commit_en !== 2'b00) $display("FAIL flush_stale_done got %b exp 00", commit_en); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd1) $display("FAIL flush_newtail got %0d exp 1", dispatch_rob_addr); else passes++;
    set_disp(2'b11, 8, 9, 10, 11);
    tick();
    clr_inputs();
    #1;
    checks++; if (commit_en !== 2'b00) $display("FAIL flush_stale_row1 got %b exp 00", commit_en); else passes++;
  endtask

  task automatic test_reset_mid();
    load_five();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clr_inputs();
    #1;
    checks++; if (empty !== 1'b1) $display("FAIL rst_empty got %0b exp 1", empty); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL rst_full got %0b exp 0", full); else passes++;
    checks++; if (commit_en !== 2'b00) $display("FAIL rst_commit got %b exp 00", commit_en); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd0) $display("FAIL rst_tail got %0d exp 0", dispatch_rob_addr); else passes++;
    checks++; if (commit_phys_rd !== '0) $display("FAIL rst_phys got %h exp 0", commit_phys_rd); else passes++;
    checks++; if (commit_arch_rd !== '0) $display("FAIL rst_arch got %h exp 0", commit_arch_rd); else passes++;
    set_disp(2'b11, 2, 3, 4, 5);
    tick();
    clr_inputs();
    #1;
    checks++; if (commit_en !== 2'b00) $display("FAIL rst_stale_done got %b exp 00", commit_en); else passes++;
    checks++; if (dispatch_rob_addr !== 4'd1) $display("FAIL rst_newtail got %0d exp 1", dispatch_rob_addr); else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    #2;
    test_reset();
    test_dispatch();
    test_writeback();
    test_full();
    test_full_commit();
    test_partial();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
